// File: rtl/key_conditioner.sv
// Push-button front end: 2-flop sync, per-key debounce, single-owner press pulses.
// Define KEY_AUTO_REPEAT_EN to add up/down auto-repeat while held.
module key_conditioner #(
  parameter int DEBOUNCE_CYC     = 2_000_000,
  parameter int REPEAT_DELAY_CYC = 50_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic       CP,
  input  logic       _CR,
  input  logic [4:0] key_raw,
  output logic       left_p,
  output logic       right_p,
  output logic       up_p,
  output logic       down_p,
  output logic       apply_p,
  output logic [2:0] held_key
);

  localparam int MAX_DR = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int MAX_P  = (DEBOUNCE_CYC > MAX_DR) ? DEBOUNCE_CYC : MAX_DR;
  localparam int CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;
  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_TERM  = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_TERM = CNT_W'(REPEAT_RATE_CYC - 1);
`endif

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [4:0] sync0_q, sync1_q, deb_q, deb_dly_q;
  logic [4:0] rise;

  always_ff @(posedge CP or posedge _CR) begin
    if (_CR) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      deb_dly_q <= '0;
    end else begin
      sync0_q   <= key_raw;
      sync1_q   <= sync0_q;
      deb_dly_q <= deb_q;
    end
  end

  // Any disagreement that does not persist DEBOUNCE_CYC cycles restarts the count.
  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;
    always_ff @(posedge CP or posedge _CR) begin
      if (_CR) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (sync1_q[i] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_TERM) begin
        lvl_q <= sync1_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign deb_q[i] = lvl_q;
  end

  assign rise = deb_q & ~deb_dly_q;

  // Ascending scan so the highest bit (apply) wins.
  logic [2:0] pick_code;
  logic [4:0] pick_oh;
  always_comb begin
    pick_code = '0;
    pick_oh   = '0;
    for (int i = 0; i < 5; i++) begin
      if (rise[i]) begin
        pick_code = 3'(i + 1);
        pick_oh   = 5'b00001 << i;
      end
    end
  end

  state_t     state_q;
  logic [2:0] owner_q;
  logic [4:0] pulse_q;
  logic       own_lvl;

  always_comb begin
    case (owner_q)
      3'd1:    own_lvl = deb_q[0];
      3'd2:    own_lvl = deb_q[1];
      3'd3:    own_lvl = deb_q[2];
      3'd4:    own_lvl = deb_q[3];
      3'd5:    own_lvl = deb_q[4];
      default: own_lvl = 1'b0;
    endcase
  end

`ifdef KEY_AUTO_REPEAT_EN
  logic [CNT_W-1:0] tmr_q;
  logic [4:0]       own_oh;
  logic             is_ud;
  assign is_ud  = (owner_q == 3'd3) || (owner_q == 3'd4);
  assign own_oh = (owner_q == 3'd4) ? 5'b01000 : 5'b00100;
`endif

  always_ff @(posedge CP or posedge _CR) begin
    if (_CR) begin
      state_q <= IDLE;
      owner_q <= '0;
      pulse_q <= '0;
`ifdef KEY_AUTO_REPEAT_EN
      tmr_q   <= '0;
`endif
    end else begin
      pulse_q <= '0;
      case (state_q)
        IDLE: begin
          if (|rise) begin
            pulse_q <= pick_oh;
            owner_q <= pick_code;
            state_q <= HOLD;
`ifdef KEY_AUTO_REPEAT_EN
            tmr_q   <= '0;
`endif
          end
        end
        HOLD: begin
          // Release is checked first so it always beats a repeat falling due.
          if (!own_lvl) begin
            state_q <= IDLE;
            owner_q <= '0;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (tmr_q == DLY_TERM) begin
            tmr_q <= '0;
            if (is_ud) begin
              pulse_q <= own_oh;
              state_q <= REPEAT;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
`endif
        end
`ifdef KEY_AUTO_REPEAT_EN
        REPEAT: begin
          if (!own_lvl) begin
            state_q <= IDLE;
            owner_q <= '0;
          end else if (tmr_q == RATE_TERM) begin
            pulse_q <= own_oh;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          owner_q <= '0;
        end
      endcase
    end
  end

  assign {apply_p, up_p, down_p, left_p, right_p} = pulse_q;
  assign held_key = owner_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner; expectations follow KEY_AUTO_REPEAT_EN when defined.
module tb_key_conditioner;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 5;
  localparam int KR = 0, KL = 1, KD = 2, KU = 3, KA = 4;

  logic       CP = 1'b0;
  logic       _CR = 1'b1;
  logic [4:0] key_raw = '0;
  logic       left_p, right_p, up_p, down_p, apply_p;
  logic [2:0] held_key;
  logic [4:0] pv;

  key_conditioner #(
    .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE)
  ) dut (
    .CP(CP), ._CR(_CR), .key_raw(key_raw),
    .left_p(left_p), .right_p(right_p), .up_p(up_p), .down_p(down_p),
    .apply_p(apply_p), .held_key(held_key)
  );

  always #5 CP = ~CP;

  assign pv = {apply_p, up_p, down_p, left_p, right_p};

  int cyc = 0;
  int checks = 0, errors = 0, multi = 0;
  int ev_c[$];
  int ev_k[$];

  always @(posedge CP) cyc <= cyc + 1;

  // Pulse log: cycle index of the edge that registered each pulse.
  always @(posedge CP) begin
    #1;
    if ($countones(pv) > 1) multi++;
    for (int i = 0; i < 5; i++)
      if (pv[i]) begin
        ev_c.push_back(cyc);
        ev_k.push_back(i);
      end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int npulse(input int k);
    int n = 0;
    foreach (ev_k[i]) if (ev_k[i] == k) n++;
    return n;
  endfunction

  function automatic int nth(input int k, input int n);
    int c = 0;
    foreach (ev_k[i])
      if (ev_k[i] == k) begin
        if (c == n) return ev_c[i];
        c++;
      end
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic clr();
    ev_c.delete();
    ev_k.delete();
  endtask

  initial begin
    int s, r;

    // 1: reset with all keys down, then release with keys still held
    key_raw = 5'h1F;
    step(4);
    chk("rst_pulses", int'(pv), 0);
    chk("rst_held", int'(held_key), 0);
    clr();
    _CR = 1'b0;
    r = cyc;
    step(10);
    chk("t1_apply_n", npulse(KA), 1);
    chk("t1_apply_cyc", nth(KA, 0), r + 7);
    chk("t1_total", ev_c.size(), 1);
    chk("t1_held", int'(held_key), 5);
    key_raw = '0;
    step(12);
    chk("t1_rel_held", int'(held_key), 0);
    chk("t1_rel_total", ev_c.size(), 1);

    // 2: bounce on up, then settle
    clr();
    for (int i = 0; i < 10; i++) begin
      key_raw = (i % 2 == 0) ? 5'h08 : 5'h00;
      step(2);
    end
    chk("t2_bounce_n", ev_c.size(), 0);
    s = cyc;
    key_raw = 5'h08;
    step(12);
    chk("t2_up_n", npulse(KU), 1);
    chk("t2_up_cyc", nth(KU, 0), s + 7);
    chk("t2_held", int'(held_key), 4);
    key_raw = '0;
    step(12);
    chk("t2_rel_held", int'(held_key), 0);
    chk("t2_total", ev_c.size(), 1);

    // 3: up held 60 cycles; last due repeat (s+67) loses to the release
    clr();
    s = cyc;
    key_raw = 5'h08;
    step(60);
    key_raw = '0;
    step(20);
`ifdef KEY_AUTO_REPEAT_EN
    chk("t3_up_n", npulse(KU), 9);
    chk("t3_up0", nth(KU, 0), s + 7);
    chk("t3_up1", nth(KU, 1), s + 27);
    chk("t3_up2", nth(KU, 2), s + 32);
    chk("t3_up8", nth(KU, 8), s + 62);
`else
    chk("t3_up_n", npulse(KU), 1);
    chk("t3_up0", nth(KU, 0), s + 7);
`endif
    chk("t3_total", ev_c.size(), npulse(KU));
    chk("t3_held", int'(held_key), 0);

    // 4: left + apply together; left stays held past apply release
    clr();
    s = cyc;
    key_raw = 5'h12;
    step(10);
    chk("t4_apply_n", npulse(KA), 1);
    chk("t4_apply_cyc", nth(KA, 0), s + 7);
    chk("t4_left_n", npulse(KL), 0);
    chk("t4_held", int'(held_key), 5);
    key_raw = 5'h02;
    step(15);
    chk("t4_held_idle", int'(held_key), 0);
    chk("t4_left_still", npulse(KL), 0);
    key_raw = '0;
    step(10);
    s = cyc;
    key_raw = 5'h02;
    step(10);
    chk("t4_left_n2", npulse(KL), 1);
    chk("t4_left_cyc", nth(KL, 0), s + 7);
    chk("t4_held_left", int'(held_key), 2);
    key_raw = '0;
    step(12);

    // 5: right held 40 cycles
    clr();
    s = cyc;
    key_raw = 5'h01;
    step(20);
    chk("t5_held_a", int'(held_key), 1);
    step(20);
    key_raw = '0;
    step(5);
    chk("t5_held_b", int'(held_key), 1);
    step(10);
    chk("t5_held_rel", int'(held_key), 0);
    chk("t5_right_n", npulse(KR), 1);
    chk("t5_right_cyc", nth(KR, 0), s + 7);
    chk("t5_total", ev_c.size(), 1);

    // 6: reset while down is held (mid-repeat when enabled)
    clr();
    s = cyc;
    key_raw = 5'h04;
    step(30);
`ifdef KEY_AUTO_REPEAT_EN
    chk("t6_pre_n", npulse(KD), 2);
`else
    chk("t6_pre_n", npulse(KD), 1);
`endif
    chk("t6_pre_held", int'(held_key), 3);
    _CR = 1'b1;
    #1;
    chk("t6_rst_held", int'(held_key), 0);
    chk("t6_rst_pulses", int'(pv), 0);
    step(3);
    clr();
    _CR = 1'b0;
    r = cyc;
    step(30);
    chk("t6_down0", nth(KD, 0), r + 7);
`ifdef KEY_AUTO_REPEAT_EN
    chk("t6_down_n", npulse(KD), 2);
    chk("t6_down1", nth(KD, 1), r + 27);
`else
    chk("t6_down_n", npulse(KD), 1);
`endif
    key_raw = '0;
    step(15);
    chk("t6_rel_held", int'(held_key), 0);

    chk("onehot", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
